// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 4-digit multiplexed 7-segment scanner with a frame-aligned load handshake.
// Optional blink (64 frames on / 64 off) is built in when DISPLAY_SCAN_BLINK_EN is defined.
module display_scan_ctrl #(
  parameter int DIV  = 50000,
  parameter int DEAD = 500
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [15:0] bcdIn,
  input  logic        load,
  output logic        loadAck,
  input  logic        blankLz,
  input  logic        blink,
  output logic [3:0]  digEn,
  output logic [6:0]  seg,
  output logic        frameStart
);
  localparam int SW = $clog2(DIV);
  typedef enum logic {BLANK, DRIVE} stateT;
  stateT state, stateNxt;
  logic [SW-1:0] sc;
  logic [1:0] idx;
  logic [15:0] shadow;
  logic slotEnd, frameEnd, capture, hide;
  logic [3:0] nib, lz, digEnNxt;
  logic [6:0] segDec, segNxt;
  assign slotEnd  = sc == SW'(DIV - 1);
  assign frameEnd = slotEnd && idx == 2'd3;
  assign capture  = frameEnd && load;
  assign nib      = shadow[{idx, 2'b00} +: 4];
  // a digit is a suppressible leading zero only if it and every higher digit are zero
  assign lz[3] = blankLz && shadow[15:12] == 4'd0;
  assign lz[2] = lz[3] && shadow[11:8] == 4'd0;
  assign lz[1] = lz[2] && shadow[7:4] == 4'd0;
  assign lz[0] = 1'b0;
`ifdef DISPLAY_SCAN_BLINK_EN
  logic [6:0] frameCnt;
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) frameCnt <= '0;
    else if (frameStart) frameCnt <= frameCnt + 7'd1;
  assign hide = blink && frameCnt[6];
`else
  assign hide = blink & 1'b0;
`endif
  always_comb begin
    segDec = 7'b1111110;
    case (nib)
      4'd0: segDec = 7'b0000001;
      4'd1: segDec = 7'b1001111;
      4'd2: segDec = 7'b0010010;
      4'd3: segDec = 7'b0000110;
      4'd4: segDec = 7'b1001100;
      4'd5: segDec = 7'b0100100;
      4'd6: segDec = 7'b0100000;
      4'd7: segDec = 7'b0001111;
      4'd8: segDec = 7'b0000000;
      4'd9: segDec = 7'b0000100;
      default: segDec = 7'b1111110;
    endcase
  end
  always_comb begin
    stateNxt = (state == BLANK && sc == SW'(DEAD - 1)) ? DRIVE :
               (state == DRIVE && slotEnd) ? BLANK : state;
    digEnNxt = (state == DRIVE && !hide) ? ~(4'b0001 << idx) : 4'b1111;
    segNxt   = (state == DRIVE && !lz[idx]) ? segDec : 7'b1111111;
  end
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      sc         <= '0;
      idx        <= '0;
      state      <= BLANK;
      shadow     <= '0;
      digEn      <= 4'b1111;
      seg        <= 7'b1111111;
      loadAck    <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      sc         <= slotEnd ? '0 : sc + 1'b1;
      idx        <= slotEnd ? idx + 2'd1 : idx;
      state      <= stateNxt;
      shadow     <= capture ? bcdIn : shadow;
      digEn      <= digEnNxt;
      seg        <= segNxt;
      loadAck    <= capture;
      frameStart <= frameEnd;
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: randomized bench comparing the scanner against a cycle-count based reference model.
module tb_display_scan_ctrl;
  localparam int DIV = 8, DEAD = 2, FRAME = 4 * DIV;
  logic Clk = 0, Rst_n = 0, load = 0, blankLz = 0, blink = 0;
  logic [15:0] bcdIn = 0;
  logic loadAck, frameStart;
  logic [3:0] digEn;
  logic [6:0] seg;
  int nTests = 0, nFail = 0;
  int n;
  logic [15:0] mShadow;
  logic [3:0] eDig;
  logic [6:0] eSeg;
  logic eAck, eFs;
  logic [6:0] segTab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                              7'h00, 7'h04, 7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h7E};
  always #5 Clk = ~Clk;
  display_scan_ctrl #(.DIV(DIV), .DEAD(DEAD)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .bcdIn(bcdIn), .load(load), .loadAck(loadAck),
    .blankLz(blankLz), .blink(blink), .digEn(digEn), .seg(seg), .frameStart(frameStart)
  );
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic modelReset();
    n = 0; mShadow = 0; eDig = 4'hF; eSeg = 7'h7F; eAck = 0; eFs = 0;
  endtask
  // n counts clock edges since reset release; slot, digit and frame follow by division
  task automatic cycle();
    int s, i, f;
    logic hide;
    @(posedge Clk);
    if (!Rst_n) modelReset();
    else begin
      s = n % DIV; i = (n / DIV) % 4; f = n / FRAME;
      hide = 0;
`ifdef DISPLAY_SCAN_BLINK_EN
      hide = blink && ((f >> 6) & 1) == 1;
`endif
      eDig = (s >= DEAD && !hide) ? ~(4'b0001 << i) : 4'hF;
      eSeg = (s < DEAD || (blankLz && i > 0 && (mShadow >> (4 * i)) == 0)) ? 7'h7F : segTab[mShadow[4*i +: 4]];
      eFs = s == DIV - 1 && i == 3;
      eAck = eFs && load;
      if (eAck) mShadow = bcdIn;
      n++;
    end
    @(negedge Clk);
    check("digEn", 16'(digEn), 16'(eDig));
    check("seg", 16'(seg), 16'(eSeg));
    check("loadAck", 16'(loadAck), 16'(eAck));
    check("frameStart", 16'(frameStart), 16'(eFs));
  endtask
  task automatic loadVal(input logic [15:0] v, input logic lzv);
    bcdIn = v; blankLz = lzv; load = 1;
    for (int k = 0; k < 2 * FRAME && !eAck; k++) cycle();
    if (!eAck) check("ackTimeout", 16'(eAck), 16'd1);
    load = 0;
    repeat (FRAME) cycle();
  endtask
  task automatic asyncReset();
    #2 Rst_n = 0;
    #1;
    check("rstDigEn", 16'(digEn), 16'hF);
    check("rstSeg", 16'(seg), 16'h7F);
    check("rstAck", 16'(loadAck), 16'd0);
    check("rstFs", 16'(frameStart), 16'd0);
    modelReset();
  endtask
  initial begin
    modelReset();
    repeat (2) cycle();
    Rst_n = 1;
    repeat (4 * FRAME) cycle();
    loadVal(16'h1234, 0);
    loadVal(16'h0070, 1);
    blankLz = 0;
    repeat (FRAME) cycle();
    loadVal(16'hA009, 0);
    bcdIn = 16'h5678; load = 1;
    repeat (3 * FRAME) cycle();
    load = 0;
    while (n % FRAME != 5) cycle();
    bcdIn = 16'h4321; load = 1;
    repeat (10) cycle();
    load = 0;
    repeat (FRAME) cycle();
    while (n % FRAME != 2 * DIV + 4) cycle();
    bcdIn = 16'h9999; load = 1;
    asyncReset();
    repeat (2) cycle();
    Rst_n = 1;
    repeat (2 * FRAME) cycle();
    load = 0;
    blink = 1;
    for (int c = 0; c < 6000; c++) begin
      cycle();
      if (load && eAck) begin
        if ($urandom_range(0, 1) == 1) load = 0;
      end else if (!load) begin
        if ($urandom_range(0, 15) == 0) begin
          bcdIn = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 999)) : 16'($urandom);
          load = 1;
        end
      end else if ($urandom_range(0, 63) == 0) load = 0;
      if ($urandom_range(0, 99) == 0) blankLz = 1'($urandom);
      if ($urandom_range(0, 1999) == 0) blink = ~blink;
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
